// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one variable-latency memory port between instruction fetch
//            and the MEM-stage data access, and generates the pipeline stalls.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic [DATA_W-1:0] IF_Data,
    output logic              IF_Valid,
    input  logic              MEM_Read,
    input  logic              MEM_Write,
    input  logic [ADDR_W-1:0] MEM_Addr,
    input  logic [DATA_W-1:0] MEM_WData,
    output logic [DATA_W-1:0] MEM_RData,
    output logic              MEM_Done,
    output logic              Mem_Req,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              Stall_MEM,
    output logic              Stall_IF,
    output logic              Timeout
);

    localparam int c_CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    // The transition to ERR is decided in the last waiting cycle, so the
    // counter only ever needs to reach MAX_WAIT-1.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [c_CNT_W-1:0]  cnt_q,       cnt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_data_q,   if_data_d;
    logic                if_valid_q,  if_valid_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_done_q,  mem_done_d;
    logic                timeout_q,   timeout_d;

    logic                w_data_pend;
    logic                w_inst_pend;
    logic                w_stall_mem;

    // A requester whose completion pulse is showing still holds its request
    // this cycle; masking with the pulse keeps it from being served twice.
    assign w_data_pend = (MEM_Read | MEM_Write) & ~mem_done_q;
    assign w_inst_pend = IF_Req & ~if_valid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (w_data_pend) begin
                    state_d     = S_DATA;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MEM_Write;
                    mem_addr_d  = MEM_Addr;
                    mem_wdata_d = MEM_WData;
                end else if (w_inst_pend) begin
                    state_d    = S_INST;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = IF_Addr;
                end
            end
            S_DATA, S_INST: begin
                if (Mem_Ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == S_DATA) begin
                        mem_done_d = 1'b1;
                        if (!mem_we_q) begin
                            mem_rdata_d = Mem_RData;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = Mem_RData;
                    end
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d   = S_ERR;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                timeout_d = 1'b1;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign w_stall_mem = w_data_pend | (state_q == S_ERR);

    assign Stall_MEM = ~RST & w_stall_mem;
    assign Stall_IF  = ~RST & (w_stall_mem | w_inst_pend);

    assign Mem_Req   = mem_req_q;
    assign Mem_WE    = mem_we_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_WData = mem_wdata_q;
    assign IF_Data   = if_data_q;
    assign IF_Valid  = if_valid_q;
    assign MEM_RData = mem_rdata_q;
    assign MEM_Done  = mem_done_q;
    assign Timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench: directed vector table, timeout / reset
//            sequences and a randomized run against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_MAX_WAIT = 4;
    localparam int c_RND_CYC  = 3000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic [31:0] IF_Data;
    logic        IF_Valid;
    logic        MEM_Read;
    logic        MEM_Write;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_WData;
    logic [31:0] MEM_RData;
    logic        MEM_Done;
    logic        Mem_Req;
    logic        Mem_WE;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic        Stall_MEM;
    logic        Stall_IF;
    logic        Timeout;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (c_MAX_WAIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IF_Req    (IF_Req),
        .IF_Addr   (IF_Addr),
        .IF_Data   (IF_Data),
        .IF_Valid  (IF_Valid),
        .MEM_Read  (MEM_Read),
        .MEM_Write (MEM_Write),
        .MEM_Addr  (MEM_Addr),
        .MEM_WData (MEM_WData),
        .MEM_RData (MEM_RData),
        .MEM_Done  (MEM_Done),
        .Mem_Req   (Mem_Req),
        .Mem_WE    (Mem_WE),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_Ack   (Mem_Ack),
        .Mem_RData (Mem_RData),
        .Stall_MEM (Stall_MEM),
        .Stall_IF  (Stall_IF),
        .Timeout   (Timeout)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // ctl = {rst, if_req, mem_read, mem_write}; eb = {req, we, ifv, done, stm, stif, to}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] ifa, ma, wd;
        logic        ack;
        logic [31:0] rdat;
        logic [6:0]  eb;
        logic [31:0] eaddr, ewd, eifd, emrd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] ctl, input logic [31:0] ifa, ma, wd,
                       input logic ack, input logic [31:0] rdat, input logic [6:0] eb,
                       input logic [31:0] eaddr, ewd, eifd, emrd);
        vec_t v;
        v.ctl = ctl; v.ifa = ifa; v.ma = ma; v.wd = wd; v.ack = ack; v.rdat = rdat;
        v.eb = eb; v.eaddr = eaddr; v.ewd = ewd; v.eifd = eifd; v.emrd = emrd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Port fields are only meaningful while a request is outstanding (or after reset).
    function automatic logic [134:0] pack(input logic req, we, input logic [31:0] addr, wdata,
                                          input logic ifv, input logic [31:0] ifd, input logic done,
                                          input logic [31:0] mrd, input logic stm, stif, to,
                                          input logic port_on, wd_on);
        return {req, port_on ? we : 1'b0, port_on ? addr : 32'h0, wd_on ? wdata : 32'h0,
                ifv, ifd, done, mrd, stm, stif, to};
    endfunction

    task automatic expect_outs(input string name, input logic port_on, input logic req, we,
                               input logic [31:0] addr, wd, input logic ifv, input logic [31:0] ifd,
                               input logic done, input logic [31:0] mrd, input logic stm, stif, to);
        logic wd_on;
        @(negedge CLK);
        wd_on = port_on & we;
        chk(name,
            pack(Mem_Req, Mem_WE, Mem_Addr, Mem_WData, IF_Valid, IF_Data, MEM_Done, MEM_RData,
                 Stall_MEM, Stall_IF, Timeout, port_on, wd_on),
            pack(req, we, addr, wd, ifv, ifd, done, mrd, stm, stif, to, port_on, wd_on));
    endtask

    task automatic set_in(input logic rst, ifr, input logic [31:0] ifa, input logic rd, wr,
                          input logic [31:0] ma, wd, input logic ack, input logic [31:0] rdat);
        RST = rst; IF_Req = ifr; IF_Addr = ifa; MEM_Read = rd; MEM_Write = wr;
        MEM_Addr = ma; MEM_WData = wd; Mem_Ack = ack; Mem_RData = rdat;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Transaction-level reference state for the randomized run.
    logic        m_busy, m_is_data, m_we, m_ifv, m_done, m_to;
    logic [31:0] m_addr, m_wdata, m_ifd, m_mrd;
    int          m_wait;
    logic [31:0] mem [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: reset, load, fetch, contention, stray ack.
        add(4'b1110, 'h40, 'h100, 0, 1'b0, 0, 7'b0000000, 0, 0, 0, 0);
        add(4'b0110, 'h40, 'h100, 0, 1'b0, 0, 7'b0000110, 0, 0, 0, 0);
        add(4'b0110, 'h40, 'h100, 0, 1'b0, 0, 7'b1000110, 'h100, 0, 0, 0);
        add(4'b0110, 'h40, 'h100, 0, 1'b0, 0, 7'b1000110, 'h100, 0, 0, 0);
        add(4'b0110, 'h40, 'h100, 0, 1'b1, 'hDEADBEEF, 7'b1000110, 'h100, 0, 0, 0);
        add(4'b0110, 'h40, 'h100, 0, 1'b0, 0, 7'b0001010, 0, 0, 0, 'hDEADBEEF);
        add(4'b0100, 'h40, 0, 0, 1'b1, 'h12345678, 7'b1000010, 'h40, 0, 0, 'hDEADBEEF);
        add(4'b0100, 'h40, 0, 0, 1'b0, 0, 7'b0010000, 0, 0, 'h12345678, 'hDEADBEEF);
        add(4'b0101, 'h44, 'h200, 'hA5A5A5A5, 1'b0, 0, 7'b0000110, 0, 0, 'h12345678, 'hDEADBEEF);
        add(4'b0101, 'h44, 'h200, 'hA5A5A5A5, 1'b1, 'h0BADF00D, 7'b1100110, 'h200, 'hA5A5A5A5,
            'h12345678, 'hDEADBEEF);
        add(4'b0101, 'h44, 'h200, 'hA5A5A5A5, 1'b0, 0, 7'b0001010, 0, 0, 'h12345678, 'hDEADBEEF);
        add(4'b0100, 'h44, 0, 0, 1'b0, 0, 7'b1000010, 'h44, 0, 'h12345678, 'hDEADBEEF);
        add(4'b0100, 'h44, 0, 0, 1'b1, 'hCAFEF00D, 7'b1000010, 'h44, 0, 'h12345678, 'hDEADBEEF);
        add(4'b0100, 'h44, 0, 0, 1'b0, 0, 7'b0010000, 0, 0, 'hCAFEF00D, 'hDEADBEEF);
        add(4'b0000, 0, 0, 0, 1'b1, 'h11111111, 7'b0000000, 0, 0, 'hCAFEF00D, 'hDEADBEEF);
        add(4'b0000, 0, 0, 0, 1'b0, 0, 7'b0000000, 0, 0, 'hCAFEF00D, 'hDEADBEEF);

        set_in(1'b1, 1'b1, 'h40, 1'b1, 1'b0, 'h100, 0, 1'b0, 0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            set_in(v.ctl[3], v.ctl[2], v.ifa, v.ctl[1], v.ctl[0], v.ma, v.wd, v.ack, v.rdat);
            expect_outs($sformatf("vec%0d", i), v.eb[6] | v.ctl[3], v.eb[6], v.eb[5], v.eaddr,
                        v.ewd, v.eb[4], v.eifd, v.eb[3], v.emrd, v.eb[2], v.eb[1], v.eb[0]);
            next_cycle();
        end

        // Timeout: no ack for MAX_WAIT cycles, sticky error, later ack ignored, reset clears.
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b0, 'h300, 0, 1'b0, 0);
        expect_outs("to_launch", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 'hCAFEF00D, 1'b0, 'hDEADBEEF,
                    1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= c_MAX_WAIT; k++) begin
            next_cycle();
            expect_outs($sformatf("to_wait%0d", k), 1'b1, 1'b1, 1'b0, 'h300, 0, 1'b0, 'hCAFEF00D,
                        1'b0, 'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        end
        next_cycle();
        expect_outs("to_err", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 'hCAFEF00D, 1'b0, 'hDEADBEEF,
                    1'b1, 1'b1, 1'b1);
        Mem_Ack = 1'b1;
        Mem_RData = 'h77777777;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            expect_outs($sformatf("to_late_ack%0d", k), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 'hCAFEF00D,
                        1'b0, 'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        end
        next_cycle();
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        expect_outs("to_sticky", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 'hCAFEF00D, 1'b0, 'hDEADBEEF,
                    1'b1, 1'b1, 1'b1);
        next_cycle();
        RST = 1'b1;
        expect_outs("to_rst_stall", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 'hCAFEF00D, 1'b0, 'hDEADBEEF,
                    1'b0, 1'b0, 1'b1);
        next_cycle();
        RST = 1'b0;
        expect_outs("to_cleared", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Reset while a data access is outstanding abandons it.
        next_cycle();
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b0, 'h500, 0, 1'b0, 0);
        expect_outs("ra_launch", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        expect_outs("ra_req", 1'b1, 1'b1, 1'b0, 'h500, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        RST = 1'b1;
        expect_outs("ra_rst", 1'b1, 1'b1, 1'b0, 'h500, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 'h55555555);
        expect_outs("ra_abandon", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        Mem_Ack = 1'b0;
        expect_outs("ra_no_done", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the transaction model.
        next_cycle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        m_busy = 1'b0; m_is_data = 1'b0; m_we = 1'b0; m_ifv = 1'b0; m_done = 1'b0; m_to = 1'b0;
        m_addr = 0; m_wdata = 0; m_ifd = 0; m_mrd = 0; m_wait = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + 32'(i);
        begin
            logic d_act, i_act, last_done, last_ifv, dp, ip, e_stm, e_stif;
            int   sel;
            d_act = 1'b0; i_act = 1'b0; last_done = 1'b0; last_ifv = 1'b0;
            for (int n = 0; n < c_RND_CYC; n++) begin
                if (last_done) d_act = 1'b0;
                if (last_ifv)  i_act = 1'b0;
                if (!d_act && $urandom_range(0, 2) == 0) begin
                    d_act     = 1'b1;
                    sel       = int'($urandom_range(0, 3));
                    MEM_Read  = (sel != 1);
                    MEM_Write = (sel == 1) || (sel == 2);
                    MEM_Addr  = 32'($urandom_range(0, 15)) << 2;
                    MEM_WData = $urandom;
                end else if (!d_act) begin
                    MEM_Read  = 1'b0;
                    MEM_Write = 1'b0;
                    MEM_Addr  = $urandom;
                    MEM_WData = $urandom;
                end
                if (!i_act && $urandom_range(0, 1) == 0) begin
                    i_act   = 1'b1;
                    IF_Addr = 32'($urandom_range(0, 255)) << 2;
                end
                IF_Req = i_act;
                if (m_busy)
                    Mem_Ack = (m_wait >= 2) || ($urandom_range(0, 1) == 1);
                else
                    Mem_Ack = ($urandom_range(0, 3) == 0);
                Mem_RData = (m_busy && m_is_data && !m_we) ? mem[m_addr[5:2]] : $urandom;

                dp     = (MEM_Read | MEM_Write) & ~m_done;
                ip     = IF_Req & ~m_ifv;
                e_stm  = dp | m_to;
                e_stif = e_stm | ip;
                expect_outs($sformatf("rnd%0d", n), m_busy, m_busy, m_we, m_addr, m_wdata,
                            m_ifv, m_ifd, m_done, m_mrd, e_stm, e_stif, m_to);

                last_done = m_done;
                last_ifv  = m_ifv;
                m_done    = 1'b0;
                m_ifv     = 1'b0;
                if (!m_to) begin
                    if (m_busy) begin
                        if (Mem_Ack) begin
                            m_busy = 1'b0;
                            if (m_is_data) begin
                                m_done = 1'b1;
                                if (m_we) mem[m_addr[5:2]] = m_wdata;
                                else      m_mrd = mem[m_addr[5:2]];
                            end else begin
                                m_ifv = 1'b1;
                                m_ifd = Mem_RData;
                            end
                        end else begin
                            m_wait++;
                            if (m_wait >= c_MAX_WAIT) begin
                                m_busy = 1'b0;
                                m_to   = 1'b1;
                            end
                        end
                    end else if (dp) begin
                        m_busy = 1'b1; m_is_data = 1'b1; m_we = MEM_Write;
                        m_addr = MEM_Addr; m_wdata = MEM_WData; m_wait = 0;
                    end else if (ip) begin
                        m_busy = 1'b1; m_is_data = 1'b0; m_we = 1'b0;
                        m_addr = IF_Addr; m_wait = 0;
                    end
                end
                next_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
